// File: rtl/alu_rs_age_ordered_pkg.sv
// alu_rs_pkg: default widths/depth and the reservation-station entry type
package alu_rs_pkg;
  localparam int RS_DEPTH = 4;
  localparam int DATA_W = 3;
  localparam int TAG_W = 2;
  localparam int OP_W = 3;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] rob_idx;
    logic [OP_W-1:0] opcode;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic rdy1;
    logic rdy2;
  } rs_entry_t;
endpackage

// File: rtl/alu_rs_age_ordered_age_matrix.sv
// rs_age_matrix: DEPTH x DEPTH age bits, one-hot grant to the oldest requester
// Ports: clk, rst_n (async, active-low), flush clears all age bits;
//   alloc_oh one-hot slot being written, live = entries surviving this edge,
//   req = issue candidates, grant = one-hot oldest candidate.
module rs_age_matrix
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] live,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic blk;
  // a newly written slot is younger than every surviving entry and older than none
  always_comb begin
    older_d = older_q;
    for (int k = 0; k < DEPTH; k++)
      if (alloc_oh[k])
        for (int j = 0; j < DEPTH; j++) begin
          older_d[j][k] = live[j] && j != k;
          older_d[k][j] = 1'b0;
        end
    if (flush) older_d = '0;
  end
  // a requester wins when no other requester is older than it
  always_comb begin
    grant = '0;
    blk = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      blk = 1'b0;
      for (int i = 0; i < DEPTH; i++) blk = blk | (req[i] & older_q[i][j]);
      grant[j] = req[j] & ~blk;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) older_q <= '0;
    else older_q <= older_d;
endmodule

// File: rtl/alu_rs_age_ordered.sv
// alu_rs_age_ordered: age-ordered ALU reservation station with CDB wakeup and dispatch bypass
// Ports: clk, rst_n (async, active-low), flush (sync kill);
//   dispatch disp_valid/disp_ready + rob tag, opcode, operand values/tags/ready bits;
//   CDB cdb_valid/cdb_tag/cdb_val; issue issue_valid/issue_ready + opcode, operands, rob tag;
//   status count, full, empty.
module alu_rs_age_ordered
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [TAG_W-1:0]  disp_rob_idx,
  input  logic [OP_W-1:0]   disp_opcode,
  input  logic [DATA_W-1:0] disp_val1,
  input  logic [DATA_W-1:0] disp_val2,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic              disp_rdy1,
  input  logic              disp_rdy2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [OP_W-1:0]   issue_opcode,
  output logic [DATA_W-1:0] issue_val1,
  output logic [DATA_W-1:0] issue_val2,
  output logic [TAG_W-1:0]  issue_rob_idx,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  rs_entry_t [DEPTH-1:0] ent_q, ent_d;
  rs_entry_t nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_v, req, grant, alloc_oh, live;
  logic [IDX_W-1:0] free_idx;
  logic disp_fire, issue_fire;
  assign count = count_q;
  assign disp_ready = count_q < CNT_W'(DEPTH);
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign disp_fire = disp_valid & disp_ready;
  assign issue_valid = |req;
  assign issue_fire = issue_valid & issue_ready;
  assign alloc_oh = disp_fire ? DEPTH'(1) << free_idx : '0;
  assign live = valid_v & ~(issue_fire ? grant : '0);
  // lowest-index free slot; count < DEPTH guarantees one exists when dispatch fires
  always_comb begin
    valid_v = '0;
    req = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      valid_v[i] = ent_q[i].valid;
      req[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end
  // issue payload is zero unless some entry is granted
  always_comb begin
    issue_opcode = '0;
    issue_val1 = '0;
    issue_val2 = '0;
    issue_rob_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) begin
        issue_opcode = ent_q[i].opcode;
        issue_val1 = ent_q[i].val1;
        issue_val2 = ent_q[i].val2;
        issue_rob_idx = ent_q[i].rob_idx;
      end
  end
  // incoming entry, picking up a same-cycle CDB broadcast for any operand still pending
  always_comb begin
    nxt.valid = 1'b1;
    nxt.rob_idx = disp_rob_idx;
    nxt.opcode = disp_opcode;
    nxt.q1 = disp_q1;
    nxt.q2 = disp_q2;
    nxt.rdy1 = disp_rdy1 | (cdb_valid & disp_q1 == cdb_tag);
    nxt.rdy2 = disp_rdy2 | (cdb_valid & disp_q2 == cdb_tag);
    nxt.val1 = disp_rdy1 ? disp_val1 : cdb_val;
    nxt.val2 = disp_rdy2 ? disp_val2 : cdb_val;
  end
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid & !ent_q[i].rdy1 & cdb_valid & ent_q[i].q1 == cdb_tag) begin
        ent_d[i].rdy1 = 1'b1;
        ent_d[i].val1 = cdb_val;
      end
      if (ent_q[i].valid & !ent_q[i].rdy2 & cdb_valid & ent_q[i].q2 == cdb_tag) begin
        ent_d[i].rdy2 = 1'b1;
        ent_d[i].val2 = cdb_val;
      end
      if (issue_fire & grant[i]) ent_d[i].valid = 1'b0;
    end
    if (disp_fire) ent_d[free_idx] = nxt;
    if (flush) ent_d = '0;
  end
  assign count_d = flush ? '0 : count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ent_q <= '0;
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
    end
  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .alloc_oh(alloc_oh),
    .live    (live),
    .req     (req),
    .grant   (grant)
  );
endmodule

// File: tb/tb_alu_rs_age_ordered.sv
// tb_alu_rs_age_ordered: directed scenarios plus randomized run against an age-ordered queue model
module tb_alu_rs_age_ordered;
  import alu_rs_pkg::*;
  localparam int D = RS_DEPTH;
  localparam int CW = $clog2(D + 1);
  localparam int PW = 1 + TAG_W + OP_W + 2 * DATA_W;
  logic clk = 0, rst_n = 0, flush = 0, disp_valid = 0, disp_ready;
  logic [TAG_W-1:0] disp_rob_idx = 0, disp_q1 = 0, disp_q2 = 0, cdb_tag = 0, issue_rob_idx;
  logic [OP_W-1:0] disp_opcode = 0, issue_opcode;
  logic [DATA_W-1:0] disp_val1 = 0, disp_val2 = 0, cdb_val = 0, issue_val1, issue_val2;
  logic disp_rdy1 = 0, disp_rdy2 = 0, cdb_valid = 0, issue_valid, issue_ready = 0, full, empty;
  logic [CW-1:0] count;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0] op;
    logic [DATA_W-1:0] v1, v2;
    logic [TAG_W-1:0] q1, q2;
    logic r1, r2;
  } op_t;
  op_t mq[$];
  always #5 clk = ~clk;
  alu_rs_age_ordered dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rob_idx(disp_rob_idx), .disp_opcode(disp_opcode), .disp_val1(disp_val1),
    .disp_val2(disp_val2), .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_rdy1(disp_rdy1),
    .disp_rdy2(disp_rdy2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
    .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_rob_idx(issue_rob_idx),
    .count(count), .full(full), .empty(empty)
  );
  function automatic int m_sel();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction
  function automatic logic [PW-1:0] exp_issue();
    int s = m_sel();
    if (s < 0) return '0;
    return {1'b1, mq[s].tag, mq[s].op, mq[s].v1, mq[s].v2};
  endfunction
  task automatic step();
    int s = m_sel();
    bit df = disp_valid && mq.size() < D;
    op_t n;
    n.tag = disp_rob_idx; n.op = disp_opcode; n.q1 = disp_q1; n.q2 = disp_q2;
    n.r1 = disp_rdy1 || (cdb_valid && disp_q1 == cdb_tag);
    n.r2 = disp_rdy2 || (cdb_valid && disp_q2 == cdb_tag);
    n.v1 = disp_rdy1 ? disp_val1 : cdb_val;
    n.v2 = disp_rdy2 ? disp_val2 : cdb_val;
    if (flush) mq.delete();
    else begin
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].r1 && mq[i].q1 == cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = cdb_val; end
        if (cdb_valid && !mq[i].r2 && mq[i].q2 == cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = cdb_val; end
      end
      if (s >= 0 && issue_ready) mq.delete(s);
      if (df) mq.push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    flush = 0; disp_valid = 0; disp_rdy1 = 0; disp_rdy2 = 0; cdb_valid = 0; issue_ready = 0;
  endtask
  task automatic drive_disp(input logic [TAG_W-1:0] t, input logic [OP_W-1:0] o,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [TAG_W-1:0] qa, input logic [TAG_W-1:0] qb,
                            input logic ra, input logic rb);
    disp_valid = 1; disp_rob_idx = t; disp_opcode = o; disp_val1 = a; disp_val2 = b;
    disp_q1 = qa; disp_q2 = qb; disp_rdy1 = ra; disp_rdy2 = rb;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({count, empty, full, disp_ready, issue_valid} !== {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_status got %b exp %b", {count, empty, full, disp_ready, issue_valid}, {CW'(0), 4'b1010});
    end
    n_vec++;
    if ({issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== '0) begin
      n_err++; $display("FAIL reset_payload got %h exp 0", {issue_rob_idx, issue_opcode, issue_val1, issue_val2});
    end
    rst_n = 1; mq.delete();
    @(negedge clk);
  endtask
  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_disp(TAG_W'((i + 2) % 4), OP_W'(i), DATA_W'(i), DATA_W'(i + 1), 0, 0, 1, 1);
      step();
    end
    idle();
    n_vec++;
    if ({full, disp_ready, count} !== {1'b1, 1'b0, CW'(4)}) begin
      n_err++; $display("FAIL fill_status got %b exp %b", {full, disp_ready, count}, {2'b10, CW'(4)});
    end
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== {1'b1, 2'd2, 3'd0, 3'd0, 3'd1}) begin
      n_err++; $display("FAIL fill_oldest got %h exp %h", {issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, {1'b1, 2'd2, 3'd0, 3'd0, 3'd1});
    end
    flush = 1; step(); idle();
  endtask
  task automatic test_wake_order();
    drive_disp(1, 1, 0, 4, 0, 0, 0, 1); step();
    drive_disp(2, 2, 0, 3, 0, 0, 0, 1); step();
    drive_disp(3, 3, 7, 1, 0, 0, 1, 1); step();
    idle();
    cdb_valid = 1; cdb_tag = 0; cdb_val = 5;
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_val1} !== {1'b1, 2'd3, 3'd7}) begin
      n_err++; $display("FAIL wake_no_forward got %h exp %h", {issue_valid, issue_rob_idx, issue_val1}, {1'b1, 2'd3, 3'd7});
    end
    step(); idle(); issue_ready = 1;
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_val1, issue_val2} !== {1'b1, 2'd1, 3'd5, 3'd4}) begin
      n_err++; $display("FAIL wake_first got %h exp %h", {issue_valid, issue_rob_idx, issue_val1, issue_val2}, {1'b1, 2'd1, 3'd5, 3'd4});
    end
    step();
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_val1, issue_val2} !== {1'b1, 2'd2, 3'd5, 3'd3}) begin
      n_err++; $display("FAIL wake_second got %h exp %h", {issue_valid, issue_rob_idx, issue_val1, issue_val2}, {1'b1, 2'd2, 3'd5, 3'd3});
    end
    step();
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_val1, issue_val2} !== {1'b1, 2'd3, 3'd7, 3'd1}) begin
      n_err++; $display("FAIL wake_third got %h exp %h", {issue_valid, issue_rob_idx, issue_val1, issue_val2}, {1'b1, 2'd3, 3'd7, 3'd1});
    end
    step(); idle();
    n_vec++;
    if ({issue_valid, empty} !== 2'b01) begin
      n_err++; $display("FAIL wake_drained got %b exp 01", {issue_valid, empty});
    end
  endtask
  task automatic test_bypass();
    drive_disp(1, 5, 2, 0, 0, 2, 1, 0);
    cdb_valid = 1; cdb_tag = 2; cdb_val = 6;
    step(); idle();
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== {1'b1, 2'd1, 3'd5, 3'd2, 3'd6}) begin
      n_err++; $display("FAIL bypass got %h exp %h", {issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, {1'b1, 2'd1, 3'd5, 3'd2, 3'd6});
    end
    issue_ready = 1; step(); idle();
  endtask
  task automatic test_full_simul();
    logic [TAG_W-1:0] order [4];
    order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 2;
    for (int i = 0; i < 4; i++) begin
      drive_disp(TAG_W'(i), 0, DATA_W'(i), DATA_W'(i), 0, 0, 1, 1); step();
    end
    drive_disp(2, 6, 5, 5, 0, 0, 1, 1); issue_ready = 1;
    n_vec++;
    if ({disp_ready, issue_rob_idx} !== {1'b0, 2'd0}) begin
      n_err++; $display("FAIL simul_blocked got %b exp %b", {disp_ready, issue_rob_idx}, 3'b000);
    end
    step();
    n_vec++;
    if ({count, disp_ready} !== {CW'(3), 1'b1}) begin
      n_err++; $display("FAIL simul_count got %b exp %b", {count, disp_ready}, {CW'(3), 1'b1});
    end
    issue_ready = 0; step(); idle();
    n_vec++;
    if ({count, full} !== {CW'(4), 1'b1}) begin
      n_err++; $display("FAIL simul_accept got %b exp %b", {count, full}, {CW'(4), 1'b1});
    end
    issue_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({issue_valid, issue_rob_idx, issue_opcode} !== {1'b1, order[i], (i == 3) ? 3'd6 : 3'd0}) begin
        n_err++; $display("FAIL simul_drain%0d got %h exp %h", i, {issue_valid, issue_rob_idx, issue_opcode}, {1'b1, order[i], (i == 3) ? 3'd6 : 3'd0});
      end
      step();
    end
    idle();
  endtask
  task automatic test_hold();
    drive_disp(0, 1, 3, 3, 0, 0, 1, 1); step();
    drive_disp(1, 2, 4, 0, 0, 3, 1, 0); step();
    idle();
    for (int c = 0; c < 3; c++) begin
      cdb_valid = c == 1; cdb_tag = 3; cdb_val = 2;
      n_vec++;
      if ({issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== {1'b1, 2'd0, 3'd1, 3'd3, 3'd3}) begin
        n_err++; $display("FAIL hold_c%0d got %h exp %h", c, {issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, {1'b1, 2'd0, 3'd1, 3'd3, 3'd3});
      end
      step();
    end
    idle(); issue_ready = 1;
    step();
    n_vec++;
    if ({issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== {1'b1, 2'd1, 3'd2, 3'd4, 3'd2}) begin
      n_err++; $display("FAIL hold_younger got %h exp %h", {issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, {1'b1, 2'd1, 3'd2, 3'd4, 3'd2});
    end
    step(); idle();
  endtask
  task automatic test_flush();
    for (int i = 1; i < 4; i++) begin
      drive_disp(TAG_W'(i), 1, 1, 1, 0, 0, 1, 1); step();
    end
    drive_disp(0, 4, 4, 4, 0, 0, 1, 1);
    flush = 1; issue_ready = 1; cdb_valid = 1;
    n_vec++;
    if ({issue_valid, issue_rob_idx} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL flush_preview got %b exp %b", {issue_valid, issue_rob_idx}, 3'b101);
    end
    step(); idle();
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if ({count, empty, issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== {CW'(0), 1'b1, 1'b0, 11'd0}) begin
        n_err++; $display("FAIL flush_c%0d got %h exp %h", c, {count, empty, issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, {CW'(0), 1'b1, 12'd0});
      end
      step();
    end
  endtask
  task automatic test_reset_mid();
    drive_disp(1, 1, 1, 1, 0, 0, 1, 1); step();
    drive_disp(2, 2, 2, 2, 0, 0, 1, 1); step();
    idle();
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({count, empty, issue_valid} !== {CW'(0), 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_mid got %b exp %b", {count, empty, issue_valid}, {CW'(0), 2'b10});
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      disp_valid = $urandom_range(0, 99) < 65;
      disp_rob_idx = TAG_W'($urandom); disp_opcode = OP_W'($urandom);
      disp_val1 = DATA_W'($urandom); disp_val2 = DATA_W'($urandom);
      disp_q1 = TAG_W'($urandom); disp_q2 = TAG_W'($urandom);
      disp_rdy1 = $urandom_range(0, 2) != 0; disp_rdy2 = $urandom_range(0, 2) != 0;
      cdb_valid = $urandom_range(0, 2) == 0; cdb_tag = TAG_W'($urandom); cdb_val = DATA_W'($urandom);
      issue_ready = $urandom_range(0, 99) < 45;
      flush = $urandom_range(0, 59) == 0;
      n_vec++;
      if ({count, full, empty, disp_ready} !== {CW'(mq.size()), mq.size() == D, mq.size() == 0, mq.size() < D}) begin
        n_err++; $display("FAIL rand_status cyc %0d got %b exp %b", c, {count, full, empty, disp_ready}, {CW'(mq.size()), mq.size() == D, mq.size() == 0, mq.size() < D});
      end
      n_vec++;
      if ({issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2} !== exp_issue()) begin
        n_err++; $display("FAIL rand_issue cyc %0d got %h exp %h", c, {issue_valid, issue_rob_idx, issue_opcode, issue_val1, issue_val2}, exp_issue());
      end
      step();
    end
    idle();
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_wake_order();
    test_bypass();
    test_full_simul();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
